// File: rtl/charlieplex_pkg.sv
// Shared types and constants for the charlieplexed key scanner.
// Pin/key counts, register map, event byte layout, scan FSM states.
package charlieplex_pkg;

  localparam int unsigned NPINS = 7;
  localparam int unsigned NKEYS = 42;

  localparam logic [2:0] ADR_STATUS = 3'd0;
  localparam logic [2:0] ADR_EVENT  = 3'd1;
  localparam logic [2:0] ADR_STABLE = 3'd2;

  localparam logic [7:0] EVT_NONE = 8'hFF;

  typedef struct packed {
    logic       pressed;
    logic       rsvd;
    logic [5:0] key;
  } event_t;

  typedef enum logic [1:0] {
    SETTLE,
    SAMPLE,
    EMIT
  } state_e;

  function automatic logic [NPINS-1:0] pin_onehot(
    input logic [2:0] p
  );
    return NPINS'(1) << p;
  endfunction

endpackage

// File: rtl/iWishbone.sv
// Minimal single-beat Wishbone-style bus bundle.
// mPeri: peripheral side (stb/we/adr/dat_c in, ack/dat_p out).
interface iWishbone;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_c;
  logic        ack;
  logic [31:0] dat_p;

  modport mPeri (
    input  clk, rst, stb, we, adr, dat_c,
    output ack, dat_p
  );

  modport mCtrl (
    input  clk, rst, ack, dat_p,
    output stb, we, adr, dat_c
  );

endinterface

// File: rtl/charlieplex_keys_sync_fifo.sv
// sync_fifo: single-clock FIFO, sync active-high reset.
// Ports: push_i/din_i, pop_i/dout_o (head), full_o, empty_o, count_o.
module sync_fifo #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [W-1:0]         din_i,
  input  logic                 pop_i,
  output logic [W-1:0]         dout_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [$clog2(D):0]   count_o
);

  localparam int unsigned AW = $clog2(D);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(D));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees the slot, so a push
  // into a full FIFO lands that cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i &&
                   (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(do_push)
                     - CW'(do_pop);
    end
  end

endmodule

// File: rtl/charlieplex_keys.sv
// Charlieplexed 7-pin / 42-key scanner with debounce, event FIFO, bus regs.
// Ports: wb (mPeri), charlieplex_i/_o/_oe; irq_o if CHARLIEPLEX_KEYS_IRQ_EN.
module charlieplex_keys
  import charlieplex_pkg::*;
#(
  parameter int unsigned nClkHz     = 12000000,
  parameter int unsigned nScanHz    = 100000,
  parameter int unsigned nFifoDepth = 8
) (
  iWishbone.mPeri          wb,
  input  logic [NPINS-1:0] charlieplex_i,
  output logic [NPINS-1:0] charlieplex_o,
  output logic [NPINS-1:0] charlieplex_oe
`ifdef CHARLIEPLEX_KEYS_IRQ_EN
  ,
  output logic             irq_o
`endif
);

  localparam int unsigned NSETTLE =
    nClkHz / nScanHz - 8;
  localparam int unsigned CNTW = $clog2(NSETTLE);
  localparam int unsigned FCW =
    $clog2(nFifoDepth) + 1;

  state_e            state_q;
  logic [2:0]        d_q;
  logic [2:0]        sidx_q;
  logic [CNTW-1:0]   cnt_q;
  logic [NPINS-1:0]  samp_q;
  logic [NKEYS-1:0]  raw_q;
  logic [NKEYS-1:0]  stable_q;
  logic [NPINS-1:0]  oe_q;
  logic              ovf_q;
  logic              ack_q;
  logic [31:0]       dat_q;

  logic [2:0]        s_cur;
  logic [5:0]        k_cur;
  logic              bit_new;
  logic              evt_push;
  event_t            evt;

  logic              accept;
  logic [2:0]        adr;
  logic              pop;
  logic              ovf_set;
  logic              ovf_clr;
  logic [7:0]        rdata;
  logic [2:0]        bidx;
  logic [47:0]       stable_ext;

  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;

  // Sense index skips the drive pin, so
  // the key offset within a phase is sidx.
  assign s_cur = (sidx_q < d_q) ? sidx_q
                                : sidx_q + 3'd1;
  assign k_cur = 6'(d_q) * 6'd6 + 6'(sidx_q);
  assign bit_new = samp_q[s_cur];

  assign evt_push = (state_q == EMIT) &&
                    (bit_new == raw_q[k_cur]) &&
                    (bit_new != stable_q[k_cur]);

  assign evt = '{pressed: bit_new,
                 rsvd:    1'b0,
                 key:     k_cur};

  assign adr    = wb.adr[2:0];
  assign accept = wb.stb && !ack_q;
  assign pop    = accept && !wb.we &&
                  (adr == ADR_EVENT) &&
                  !fifo_empty;
  assign ovf_clr = accept && wb.we &&
                   (adr == ADR_STATUS) &&
                   wb.dat_c[7];
  // Only a truly dropped event is an overflow.
  assign ovf_set = evt_push && fifo_full && !pop;

  assign stable_ext = {6'b0, stable_q};
  assign bidx = adr - ADR_STABLE;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (adr == ADR_STATUS):
        rdata = {ovf_q, 2'b00, 5'(fifo_count)};
      (adr == ADR_EVENT):
        rdata = fifo_empty ? EVT_NONE
                           : fifo_dout;
      default:
        rdata = stable_ext[{bidx, 3'b000} +: 8];
    endcase
  end

  sync_fifo #(
    .W (8),
    .D (nFifoDepth)
  ) u_fifo (
    .clk_i   (wb.clk),
    .rst_i   (wb.rst),
    .push_i  (evt_push),
    .din_i   (evt),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      state_q  <= SETTLE;
      d_q      <= '0;
      sidx_q   <= '0;
      cnt_q    <= '0;
      samp_q   <= '0;
      raw_q    <= '0;
      stable_q <= '0;
      oe_q     <= '0;
    end else begin
      unique case (state_q)
        SETTLE: begin
          oe_q <= pin_onehot(d_q);
          if (cnt_q == CNTW'(NSETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        SAMPLE: begin
          samp_q  <= ~charlieplex_i;
          sidx_q  <= '0;
          state_q <= EMIT;
        end
        EMIT: begin
          raw_q[k_cur] <= bit_new;
          if (evt_push) begin
            stable_q[k_cur] <= bit_new;
          end
          if (sidx_q == 3'd5) begin
            sidx_q  <= '0;
            state_q <= SETTLE;
            if (d_q == 3'd6) begin
              d_q  <= '0;
              oe_q <= pin_onehot(3'd0);
            end else begin
              d_q  <= d_q + 3'd1;
              oe_q <= pin_onehot(d_q + 3'd1);
            end
          end else begin
            sidx_q <= sidx_q + 3'd1;
          end
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= accept;
      dat_q <= (accept && !wb.we) ?
               {24'b0, rdata} : '0;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef CHARLIEPLEX_KEYS_IRQ_EN
  logic irq_q;

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= !fifo_empty || ovf_q;
    end
  end

  assign irq_o = irq_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{wb.adr[31:3],
                       wb.dat_c[31:8],
                       wb.dat_c[6:0]};

  assign wb.ack         = ack_q;
  assign wb.dat_p       = dat_q;
  assign charlieplex_o  = '0;
  assign charlieplex_oe = oe_q;

endmodule
